mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that computes a 16x16 -> 16-bit product by repeatedly borrowing the shared execute-stage ALU. It uses the ALU's ADD (R-format) and SLLI operations under shift-and-add control.
- Sits beside the ALU in EX. While it owns the ALU, it drives the ALU's OpCode/funct/Rs/Rt/Imm inputs through the EX operand mux and stalls the pipeline.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request: latch a/b and begin; honoured only in IDLE or DONE
- kill  in  1  pipeline flush; abort the current operation
- a  in  16  multiplicand
- b  in  16  multiplier
- alu_res  in  16  combinational result from the shared ALU, same cycle
- alu_own  out  1  1 = EX mux selects this block's ALU inputs
- alu_opcode  out  5  ALU OpCode
- alu_funct  out  2  ALU funct
- alu_rs  out  16  ALU Rs operand
- alu_rt  out  16  ALU Rt operand
- alu_imm  out  8  ALU Imm field
- busy  out  1  high in ADD/SHIFT; drives pipeline stall
- done  out  1  one-cycle pulse; product valid
- product  out  16  low 16 bits of a*b; held until the next accepted start

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, product=0, done=0, busy=0, alu_own=0. All ALU outputs are 0.
- States: IDLE, ADD, SHIFT, DONE. Registers: acc[15:0], mcand[15:0], mplier[15:0].
- Accept (IDLE or DONE, start=1, kill=0):
  - Load acc=0, mcand=a, mplier=b.
  - Next state: DONE if b==0; else ADD if b[0]=1; else SHIFT.
- ADD:
  - Drive alu_opcode=5'b11011, funct=2'b00, rs=acc, rt=mcand, imm=0.
  - Clock edge: acc<=alu_res. Next state is SHIFT.
- SHIFT:
  - Drive alu_opcode=5'b10100 (SLLI), funct=0, rs=mcand, rt=0, imm=8'd1.
  - Clock edge: mcand<=alu_res, m'=mplier>>1, mplier<=m'.
  - Next state: DONE if m'==0; else ADD if m'[0]; else SHIFT.
- DONE:
  - done=1 for exactly this cycle; product<=acc on entry.
  - Next state: IDLE, or an accept if start=1 (back-to-back allowed).
- alu_own=busy=1 exactly in ADD/SHIFT. In IDLE/DONE, all ALU outputs are 0.
- Latency: accepted at edge T gives done high in cycle T+1+popcount(b)+(msb_index(b)+1). For b=0, done is at T+1. The worst case, b=16'hFFFF, gives T+33. At most 16 SHIFTs occur; no counter is needed because mplier empties.
- Arithmetic: modulo 2^16, no overflow indication. The result is identical for signed and unsigned operands (two's-complement low half).
- start in ADD/SHIFT is ignored; there is no queueing.
- kill in any state: next state IDLE, done=0. product is unchanged. kill wins over a simultaneous start.
- rst mid-operation: full reset values next cycle; rst has priority over kill and start.
- a/b are sampled only at accept; later changes have no effect.

Decomposition:
- Shared package `wisc_alu_pkg`:
  - ALU opcode/funct constants: OP_RTYPE=5'b11011, FN_ADD=2'b00, OP_SLLI=5'b10100.
  - State encoding for IDLE/ADD/SHIFT/DONE (2-bit).
- One sub-module: `mul_seq_fsm`, covering the state register and next-state/decode logic from (start, kill, mplier).
- acc/mcand/mplier/product registers and the ALU-drive mux stay in the top module.

Test Plan:
- a=3, b=5, start at T -> ADD,SHIFT,SHIFT,ADD,SHIFT; done at T+6, product=16'd15; busy high T+1..T+5.
- a=16'h1234, b=0 -> no ADD/SHIFT, alu_own never high; done at T+1, product=0.
- a=16'hFFFF, b=16'hFFFF -> done at T+33, product=16'h0001 (also checks -1*-1=1 signed).
- Back-to-back: 7*6 then start again during the DONE cycle with 16'h0100*16'h0100 -> first product=42; second accepted without an IDLE cycle, product=16'h0000 (truncation).
- kill asserted in the 3rd busy cycle of 9*9, with start also high -> IDLE next cycle, no done pulse, product keeps its prior value, start ignored.
- rst asserted mid-operation -> next cycle all outputs at reset values; a following start 2*3 gives product=6.

Source files
------------

// File: rtl/wisc_alu_pkg.sv
// Shared execute-stage ALU encodings and the multiply sequencer's state type.
// Both the sequencer and its FSM import this package.
package wisc_alu_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b11011;
  localparam logic [1:0] FN_ADD   = 2'b00;
  localparam logic [4:0] OP_SLLI  = 5'b10100;

  localparam int MUL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

  // Where to go once the multiplier holds m: empty means finished, else add or skip.
  function automatic mul_state_e seq_state(input logic [MUL_W-1:0] m);
    if (m == '0) begin
      return ST_DONE;
    end else if (m[0]) begin
      return ST_ADD;
    end else begin
      return ST_SHIFT;
    end
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Bundle between the multiply sequencer, the pipeline control and the shared ALU.
// The slave modport is the sequencer's view.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             kill;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_own;
  logic [4:0]       alu_opcode;
  logic [1:0]       alu_funct;
  logic [WIDTH-1:0] alu_rs;
  logic [WIDTH-1:0] alu_rt;
  logic [7:0]       alu_imm;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;

  modport master (
    output start, kill, a, b, alu_res,
    input  alu_own, alu_opcode, alu_funct, alu_rs, alu_rt, alu_imm,
    input  busy, done, product
  );

  modport slave (
    input  start, kill, a, b, alu_res,
    output alu_own, alu_opcode, alu_funct, alu_rs, alu_rt, alu_imm,
    output busy, done, product
  );

endinterface

// File: rtl/mul_seq_fsm.sv
// State register and next-state decode for the shift-and-add multiply sequencer.
// The multiplier register emptying out ends the loop, so no iteration counter exists.
module mul_seq_fsm
  import wisc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] mplier_i,
  output mul_state_e       state_o,
  output mul_state_e       state_next_o,
  output logic             accept_o
);

  mul_state_e state_q;
  mul_state_e state_d;
  logic       accept_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    // A flush beats everything, including a start arriving in the same cycle.
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            accept_d = 1'b1;
            state_d  = seq_state(b_i);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADD:   state_d = ST_SHIFT;
        ST_SHIFT: state_d = seq_state(mplier_i >> 1);
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign state_o      = state_q;
  assign state_next_o = state_d;
  assign accept_o     = accept_d;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 16x16->16 multiplier that borrows the EX-stage ALU for ADD and SLLI
// steps, stalling the pipeline while it owns the ALU operand mux.
module mul_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  mul_seq_ctrl_if.slave   bus
);

  import wisc_alu_pkg::*;

  mul_state_e       state_q;
  mul_state_e       state_d;
  logic             accept;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;

  logic             own;
  logic [4:0]       opcode;
  logic [1:0]       funct;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [7:0]       imm;

  mul_seq_fsm #(
    .WIDTH (WIDTH)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start_i      (bus.start),
    .kill_i       (bus.kill),
    .b_i          (bus.b),
    .mplier_i     (mplier_q),
    .state_o      (state_q),
    .state_next_o (state_d),
    .accept_o     (accept)
  );

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    if (accept) begin
      acc_d    = '0;
      mcand_d  = bus.a;
      mplier_d = bus.b;
    end else if (!bus.kill) begin
      unique case (state_q)
        ST_ADD: acc_d = bus.alu_res;
        ST_SHIFT: begin
          mcand_d  = bus.alu_res;
          mplier_d = mplier_q >> 1;
        end
        default: ;
      endcase
    end
    // Capture the accumulator value that will stand at DONE entry; for b==0 that is the fresh zero.
    if (state_d == ST_DONE) begin
      product_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    own    = 1'b0;
    opcode = '0;
    funct  = '0;
    rs     = '0;
    rt     = '0;
    imm    = '0;
    unique case (state_q)
      ST_ADD: begin
        own    = 1'b1;
        opcode = OP_RTYPE;
        funct  = FN_ADD;
        rs     = acc_q;
        rt     = mcand_q;
      end
      ST_SHIFT: begin
        own    = 1'b1;
        opcode = OP_SLLI;
        rs     = mcand_q;
        imm    = 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.alu_own    = own;
  assign bus.alu_opcode = opcode;
  assign bus.alu_funct  = funct;
  assign bus.alu_rs     = rs;
  assign bus.alu_rt     = rt;
  assign bus.alu_imm    = imm;
  assign bus.busy       = own;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.product    = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural ALU and a product/latency scoreboard.
// Each accepted start pushes the expected product and done latency; each done pops one.
module tb_mul_seq_ctrl;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [15:0] last_prod;

  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.WIDTH(16)) bus ();

  mul_seq_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared ALU: R-type ADD and SLLI only.
  assign bus.alu_res = (bus.alu_opcode == 5'b11011 && bus.alu_funct == 2'b00) ? bus.alu_rs + bus.alu_rt :
                       (bus.alu_opcode == 5'b10100) ? bus.alu_rs << bus.alu_imm[3:0] : 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
    int pc = 0;
    int msb = -1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
    return (b == 16'h0) ? 1 : 1 + pc + msb + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [15:0] p;
    p = a * b;
    e.prod = p;
    e.lat  = exp_lat(b);
    e.a    = a;
    e.b    = b;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int   edges;
    exp_t e;
    tick();
    edges = 1;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && edges < 40) begin
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      check({tag, "_own"}, {31'd0, bus.alu_own}, 32'd1);
      tick();
      edges++;
    end
    check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      check({tag, "_latency"}, edges, e.lat);
      check({tag, "_product"}, {16'd0, bus.product}, {16'd0, e.prod});
      check({tag, "_busy_lo"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_own_lo"}, {31'd0, bus.alu_own}, 32'd0);
      $display("txn %s: a=%h b=%h product=%h latency=%0d", tag, e.a, e.b, bus.product, edges);
      last_prod = e.prod;
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [15:0] prod);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_own"}, {31'd0, bus.alu_own}, 32'd0);
    check({tag, "_alu_ops"}, {bus.alu_opcode, bus.alu_funct, bus.alu_imm}, 32'd0);
    check({tag, "_alu_rsrt"}, {bus.alu_rs, bus.alu_rt}, 32'd0);
    check({tag, "_product"}, {16'd0, bus.product}, {16'd0, prod});
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    last_prod = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_idle_outputs("reset", 16'h0000);

    // 3*5: ADD,SHIFT,SHIFT,ADD,SHIFT then DONE at T+6
    issue(16'd3, 16'd5);
    wait_done("mul_3x5");
    tick();
    check("mul_3x5_done_pulse", {31'd0, bus.done}, 32'd0);

    // kill in the third busy cycle of 9*9 with start also asserted
    bus.a = 16'd9;
    bus.b = 16'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("kill_busy1", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    check("kill_busy3", {31'd0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    bus.start = 1'b1;
    bus.a = 16'd5;
    bus.b = 16'd5;
    tick();
    bus.kill = 1'b0;
    bus.start = 1'b0;
    check_idle_outputs("kill_next", last_prod);
    for (int i = 0; i < 5; i++) begin
      check("kill_quiet", {30'd0, bus.busy, bus.done}, 32'd0);
      tick();
    end
    $display("txn kill_9x9: product held at %h", bus.product);

    // b == 0 goes straight to DONE
    issue(16'h1234, 16'h0000);
    wait_done("mul_b0");
    tick();
    check("mul_b0_done_pulse", {31'd0, bus.done}, 32'd0);

    // back-to-back: second start during the DONE cycle
    issue(16'd7, 16'd6);
    wait_done("b2b_first");
    issue(16'h0100, 16'h0100);
    wait_done("b2b_second");
    tick();

    // worst case, also -1 * -1 == 1
    issue(16'hFFFF, 16'hFFFF);
    wait_done("mul_ffff");
    tick();

    // reset mid-operation
    bus.a = 16'hABCD;
    bus.b = 16'h00FF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_mid", 16'h0000);
    $display("txn rst_mid: outputs back to reset values");
    issue(16'd2, 16'd3);
    wait_done("mul_2x3");
    tick();

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
